// File: rtl/img_rom_reader.sv
// Image ROM read initiator: places an IMG_W x IMG_H picture inside the active video area and
// returns pixels with delay-matched syncs. Define IMG_BINARIZE_EN for a luma-threshold output stage.
module img_rom_reader #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 24,
    parameter int                    IMG_W      = 256,
    parameter int                    IMG_H      = 256,
    parameter int                    X_OFS      = 0,
    parameter int                    Y_OFS      = 0,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR   = '0
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  vs_in,
    input  logic                  hs_in,
    input  logic                  de_in,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_rd_en,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic [7:0]            threshold,
    output logic                  vs_out,
    output logic                  hs_out,
    output logic                  de_out,
    output logic [DATA_WIDTH-1:0] pix_out
);
    localparam int CW = 16;
    localparam logic [31:0] X_LO = 32'(X_OFS);
    localparam logic [31:0] X_HI = 32'(X_OFS + IMG_W);
    localparam logic [31:0] Y_LO = 32'(Y_OFS);
    localparam logic [31:0] Y_HI = 32'(Y_OFS + IMG_H);

    typedef enum logic {WAIT_VS, RUN} state_t;
    state_t r_state, w_state_nxt;

    logic                  r_vs_d, r_de_d;
    logic [CW-1:0]         r_x, r_y, w_x, w_y;
    logic [ADDR_WIDTH-1:0] r_ptr, w_ptr;
    logic                  w_vs_rise, w_de_rise, w_de_fall, w_run, w_in_win;
    // per stage: {in-window, vs, hs, de}
    logic [RD_LATENCY:0][3:0] r_vld_pipe;
    logic [3:0]               w_tail;

    assign w_vs_rise = vs_in & ~r_vs_d;
    assign w_de_rise = de_in & ~r_de_d;
    assign w_de_fall = ~de_in & r_de_d;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == WAIT_VS && w_vs_rise) w_state_nxt = RUN;
    end

    // A vs edge takes effect in its own cycle: clears y and the pointer before the window test.
    assign w_run = (r_state == RUN) | w_vs_rise;
    assign w_x   = w_de_rise ? '0 : r_x;
    assign w_y   = w_vs_rise ? '0 : r_y;
    assign w_ptr = w_vs_rise ? '0 : r_ptr;

    assign w_in_win = w_run && de_in &&
                      (32'(w_x) >= X_LO) && (32'(w_x) < X_HI) &&
                      (32'(w_y) >= Y_LO) && (32'(w_y) < Y_HI);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state    <= WAIT_VS;
            r_vs_d     <= 1'b0;
            r_de_d     <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_ptr      <= '0;
            rom_addr   <= '0;
            rom_rd_en  <= 1'b0;
            r_vld_pipe <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vs_d  <= vs_in;
            r_de_d  <= de_in;
            if (de_in) r_x <= (w_x == '1) ? w_x : w_x + CW'(1);
            if (w_de_fall) r_y <= (w_y == '1) ? w_y : w_y + CW'(1);
            else           r_y <= w_y;
            r_ptr     <= w_in_win ? w_ptr + ADDR_WIDTH'(1) : w_ptr;
            rom_rd_en <= w_in_win;
            if (w_in_win) rom_addr <= w_ptr;
            r_vld_pipe[0] <= {w_in_win, vs_in, hs_in, de_in};
            for (int i = 1; i <= RD_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
    end

    // Tail stage lines up with rom_data for the same sample.
    assign w_tail = r_vld_pipe[RD_LATENCY];

`ifdef IMG_BINARIZE_EN
    logic [16:0] w_sum;
    logic [7:0]  w_luma;
    logic [3:0]  r_bin_sync;
    logic        r_white;

    assign w_sum  = 17'd77  * 17'(rom_data[23:16]) +
                    17'd150 * 17'(rom_data[15:8]) +
                    17'd29  * 17'(rom_data[7:0]);
    assign w_luma = w_sum[15:8];

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_bin_sync <= '0;
            r_white    <= 1'b0;
            vs_out     <= 1'b0;
            hs_out     <= 1'b0;
            de_out     <= 1'b0;
            pix_out    <= '0;
        end else begin
            r_bin_sync <= w_tail;
            r_white    <= (w_luma >= threshold);
            {vs_out, hs_out, de_out} <= r_bin_sync[2:0];
            pix_out <= r_bin_sync[3] ? (r_white ? '1 : '0) : BG_COLOR;
        end
    end
`else
    logic w_unused_thr;
    assign w_unused_thr = ^threshold;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            vs_out  <= 1'b0;
            hs_out  <= 1'b0;
            de_out  <= 1'b0;
            pix_out <= '0;
        end else begin
            {vs_out, hs_out, de_out} <= w_tail[2:0];
            pix_out <= w_tail[3] ? rom_data : BG_COLOR;
        end
    end
`endif
endmodule
